// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: a per-instruction state machine that drives the
// datapath mux selects and write enables, stalling on the shared memory's ready handshake.
module mips_multicycle_control (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       mem_to_reg,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ior_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] alu_op,
  output logic       illegal
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  localparam logic [1:0] SrcBReg    = 2'd0;
  localparam logic [1:0] SrcBFour   = 2'd1;
  localparam logic [1:0] SrcBImm    = 2'd2;
  localparam logic [1:0] SrcBImmSh2 = 2'd3;

  localparam logic [1:0] AluAdd   = 2'd0;
  localparam logic [1:0] AluSub   = 2'd1;
  localparam logic [1:0] AluFunct = 2'd2;

  localparam logic [1:0] PcAluResult = 2'd0;
  localparam logic [1:0] PcAluOut    = 2'd1;
  localparam logic [1:0] PcJump      = 2'd2;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StRExec    = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StAddiExec = 4'd10,
    StAddiWb   = 4'd11
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:    state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (opcode)
          OpLw, OpSw: state_d = StMemAddr;
          OpRtype:    state_d = StRExec;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StAddiExec;
          default:    state_d = StFetch;
        endcase
      end
      StMemAddr: begin
        if (opcode == OpLw) begin
          state_d = StMemRead;
        end else if (opcode == OpSw) begin
          state_d = StMemWrite;
        end else begin
          state_d = StFetch;
        end
      end
      StMemRead:  state_d = mem_ready ? StMemWb : StMemRead;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = mem_ready ? StFetch : StMemWrite;
      StRExec:    state_d = StRWb;
      StRWb:      state_d = StFetch;
      StBranch:   state_d = StFetch;
      StJump:     state_d = StFetch;
      StAddiExec: state_d = StAddiWb;
      StAddiWb:   state_d = StFetch;
      default:    state_d = StFetch;
    endcase
  end

  // Outputs are decoded from state and forced low while reset is high, so an
  // aborted instruction cannot leave a write enable asserted.
  always_comb begin
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SrcBReg;
    mem_to_reg    = 1'b0;
    pc_src        = PcAluResult;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ior_d         = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    alu_op        = AluAdd;
    illegal       = 1'b0;
    if (!reset) begin
      case (state_q)
        StFetch: begin
          mem_read  = 1'b1;
          alu_src_b = SrcBFour;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        StDecode: begin
          alu_src_b = SrcBImmSh2;
          case (opcode)
            OpLw, OpSw, OpRtype, OpBeq, OpJ, OpAddi: illegal = 1'b0;
            default:                                 illegal = 1'b1;
          endcase
        end
        StMemAddr, StAddiExec: begin
          alu_src_a = 1'b1;
          alu_src_b = SrcBImm;
        end
        StMemRead: begin
          mem_read = 1'b1;
          ior_d    = 1'b1;
        end
        StMemWb: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        StMemWrite: begin
          mem_write = 1'b1;
          ior_d     = 1'b1;
        end
        StRExec: begin
          alu_src_a = 1'b1;
          alu_op    = AluFunct;
        end
        StRWb: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        StBranch: begin
          alu_src_a     = 1'b1;
          alu_op        = AluSub;
          pc_write_cond = 1'b1;
          pc_src        = PcAluOut;
        end
        StJump: begin
          pc_write = 1'b1;
          pc_src   = PcJump;
        end
        StAddiWb: begin
          reg_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: walks each instruction class state by state
// and compares the full packed output vector against hand-built per-state constants.
module tb_mips_multicycle_control;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       reg_dst, alu_src_a, mem_to_reg;
  logic [1:0] alu_src_b, pc_src, alu_op;
  logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write, reg_write;
  logic       illegal;

  int checks = 0;
  int errors = 0;

  mips_multicycle_control dut (
    .clock         (clock),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .reg_dst       (reg_dst),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .mem_to_reg    (mem_to_reg),
    .pc_src        (pc_src),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .ior_d         (ior_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .alu_op        (alu_op),
    .illegal       (illegal)
  );

  always #5 clock = ~clock;

  // Packing: reg_dst alu_src_a alu_src_b mem_to_reg pc_src pc_write pc_write_cond
  //          ior_d mem_read mem_write ir_write reg_write alu_op illegal
  logic [16:0] outs;
  assign outs = {reg_dst, alu_src_a, alu_src_b, mem_to_reg, pc_src, pc_write, pc_write_cond,
                 ior_d, mem_read, mem_write, ir_write, reg_write, alu_op, illegal};

  localparam logic [16:0] EZero     = 17'b0_0_00_0_00_0_0_0_0_0_0_0_00_0;
  localparam logic [16:0] EFetchRdy = 17'b0_0_01_0_00_1_0_0_1_0_1_0_00_0;
  localparam logic [16:0] EFetchStl = 17'b0_0_01_0_00_0_0_0_1_0_0_0_00_0;
  localparam logic [16:0] EDecode   = 17'b0_0_11_0_00_0_0_0_0_0_0_0_00_0;
  localparam logic [16:0] EDecIll   = 17'b0_0_11_0_00_0_0_0_0_0_0_0_00_1;
  localparam logic [16:0] EAddrImm  = 17'b0_1_10_0_00_0_0_0_0_0_0_0_00_0;
  localparam logic [16:0] EMemRead  = 17'b0_0_00_0_00_0_0_1_1_0_0_0_00_0;
  localparam logic [16:0] EMemWb    = 17'b0_0_00_1_00_0_0_0_0_0_0_1_00_0;
  localparam logic [16:0] EMemWrite = 17'b0_0_00_0_00_0_0_1_0_1_0_0_00_0;
  localparam logic [16:0] ERExec    = 17'b0_1_00_0_00_0_0_0_0_0_0_0_10_0;
  localparam logic [16:0] ERWb      = 17'b1_0_00_0_00_0_0_0_0_0_0_1_00_0;
  localparam logic [16:0] EBranch   = 17'b0_1_00_0_01_0_1_0_0_0_0_0_01_0;
  localparam logic [16:0] EJump     = 17'b0_0_00_0_10_1_0_0_0_0_0_0_00_0;
  localparam logic [16:0] EAddiWb   = 17'b0_0_00_0_00_0_0_0_0_0_0_1_00_0;

  localparam logic [5:0] OpR = 6'b000000, OpLw = 6'b100011, OpSw = 6'b101011;
  localparam logic [5:0] OpBeq = 6'b000100, OpJ = 6'b000010, OpAddi = 6'b001000;
  localparam logic [5:0] OpBad = 6'b111111;

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs, check outputs mid-cycle, then advance past the next edge.
  task automatic cyc(input string tag, input logic rdy, input logic [5:0] op,
                     input logic [16:0] exp);
    mem_ready = rdy;
    opcode    = op;
    #1;
    check(tag, outs, exp);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b1;
    opcode    = OpR;
    #2;
    check("reset_outputs", outs, EZero);
    @(posedge clock);
    #1;
    check("reset_held", outs, EZero);
    reset = 1'b0;
    #1;
    check("after_reset_fetch", outs, EFetchRdy);

    // lw, ready tied high: 5 cycles
    cyc("lw_fetch", 1'b1, OpLw, EFetchRdy);
    cyc("lw_decode", 1'b1, OpLw, EDecode);
    cyc("lw_addr", 1'b1, OpLw, EAddrImm);
    cyc("lw_read", 1'b1, OpLw, EMemRead);
    cyc("lw_wb", 1'b1, OpLw, EMemWb);

    // sw with three stall cycles in MEM_WRITE: 7 cycles; mem_ready ignored in DECODE
    cyc("sw_fetch", 1'b1, OpSw, EFetchRdy);
    cyc("sw_decode", 1'b0, OpSw, EDecode);
    cyc("sw_addr", 1'b0, OpSw, EAddrImm);
    cyc("sw_write_stall0", 1'b0, OpSw, EMemWrite);
    cyc("sw_write_stall1", 1'b0, OpR, EMemWrite);
    cyc("sw_write_stall2", 1'b0, OpR, EMemWrite);
    cyc("sw_write_done", 1'b1, OpR, EMemWrite);

    // R-type, beq, j back to back
    cyc("r_fetch", 1'b1, OpR, EFetchRdy);
    cyc("r_decode", 1'b1, OpR, EDecode);
    cyc("r_exec", 1'b1, OpR, ERExec);
    cyc("r_wb", 1'b1, OpR, ERWb);
    cyc("beq_fetch", 1'b1, OpBeq, EFetchRdy);
    cyc("beq_decode", 1'b1, OpBeq, EDecode);
    cyc("beq_branch", 1'b1, OpBeq, EBranch);
    cyc("j_fetch", 1'b1, OpJ, EFetchRdy);
    cyc("j_decode", 1'b1, OpJ, EDecode);
    cyc("j_jump", 1'b1, OpJ, EJump);

    // FETCH stall two cycles, then addi
    cyc("fetch_stall0", 1'b0, OpBad, EFetchStl);
    cyc("fetch_stall1", 1'b0, OpBad, EFetchStl);
    cyc("addi_fetch", 1'b1, OpAddi, EFetchRdy);
    cyc("addi_decode", 1'b1, OpAddi, EDecode);
    cyc("addi_exec", 1'b0, OpAddi, EAddrImm);
    cyc("addi_wb", 1'b0, OpAddi, EAddiWb);

    // Illegal opcode: one-cycle pulse then back to FETCH
    cyc("ill_fetch", 1'b1, OpBad, EFetchRdy);
    cyc("ill_decode", 1'b1, OpBad, EDecIll);
    cyc("ill_back_fetch", 1'b1, OpBad, EFetchRdy);

    // Reset asserted mid-R_EXEC aborts immediately
    cyc("r2_decode", 1'b1, OpR, EDecode);
    #2;
    check("r2_exec", outs, ERExec);
    reset = 1'b1;
    #1;
    check("async_reset_mid_rexec", outs, EZero);
    @(posedge clock);
    #1;
    check("reset_held_no_wb", outs, EZero);
    reset = 1'b0;
    #1;
    check("post_abort_fetch", outs, EFetchRdy);
    mem_ready = 1'b0;
    #1;
    check("post_abort_fetch_stall", outs, EFetchStl);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
